seg_display_ctrl: RTL and testbench

Parametrised N-digit multiplexed seven-segment display controller, the successor to the board's fixed 2-of-4-digit hex display. It latches a binary value on a load strobe, shows it in hex or in decimal (a sequential binary-to-BCD converter produces the digits), and scans the anodes at a programmable refresh rate. Supported extras:
- leading-zero blanking
- per-digit decimal points
- global blanking
- a decimal overflow indication

It sits between the CPU/system top level and the board's `seg`/`an`/`dp` pins, on the system clock.

---
 rtl/seg_pkg.sv | 47 ++++
 rtl/bin2bcd_seq.sv | 82 ++++++++
 rtl/seg_display_ctrl.sv | 130 +++++++++++++
 tb/tb_seg_display_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types, constants and helpers for the multiplexed seven-segment display controller.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    CONV_IDLE,
    CONV_SHIFT,
    CONV_DONE
  } conv_state_e;

  function automatic int bcd_width(input int digits);
    return 4 * digits;
  endfunction

  // Largest value representable in `digits` decimal digits, i.e. 10^digits - 1.
  function automatic logic [63:0] dec_max(input int digits);
    logic [63:0] v;
    v = 64'd1;
    for (int i = 0; i < digits; i++) v = v * 64'd10;
    return v - 64'd1;
  endfunction

  // Segment order is g..a, active-low.
  function automatic logic [6:0] seg_encode(input logic [3:0] code);
    case (code)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one input bit per cycle, DATA_W shift cycles,
// then a single DONE cycle in which bcd/overflow are valid.
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_W-1:0]     data,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int BCD_W = bcd_width(DIGITS);
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [63:0] MAX_VAL = dec_max(DIGITS);

  conv_state_e       state, state_next;
  logic [DATA_W-1:0] shift_q;
  logic [BCD_W-1:0]  bcd_q;
  logic [BCD_W-1:0]  bcd_adj;
  logic [BCD_W:0]    bcd_shift;
  logic [CNT_W-1:0]  cnt_q;
  logic              ovf_q;

  // NOTE: always_comb uses blocking '=' and assigns every output a default first,
  // so later statements see earlier results and no latch can be inferred.
  always_comb begin
    state_next = state;
    case (state)
      CONV_IDLE:  if (start) state_next = CONV_SHIFT;
      CONV_SHIFT: if (cnt_q == CNT_W'(DATA_W - 1)) state_next = CONV_DONE;
      CONV_DONE:  state_next = start ? CONV_SHIFT : CONV_IDLE;
      default:    state_next = CONV_IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_q[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
    end
    bcd_shift = {bcd_adj, shift_q[DATA_W-1]};
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CONV_IDLE;
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state <= state_next;
      if (start && state != CONV_SHIFT) begin
        shift_q <= data;
        bcd_q   <= '0;
        cnt_q   <= '0;
        ovf_q   <= (64'(data) > MAX_VAL);
      end else if (state == CONV_SHIFT) begin
        shift_q <= shift_q << 1;
        bcd_q   <= bcd_shift[BCD_W-1:0];
        cnt_q   <= cnt_q + 1'b1;
        // A digit carried out of the top means the value did not fit either.
        ovf_q   <= ovf_q | bcd_shift[BCD_W];
      end
    end
  end

  assign busy     = (state != CONV_IDLE);
  assign done     = (state == CONV_DONE);
  assign bcd      = bcd_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/seg_display_ctrl.sv
// N-digit multiplexed seven-segment controller: latches a value in hex or decimal,
// scans the anodes at REFRESH_DIV cycles per digit and drives registered pins.
module seg_display_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int DATA_W      = 16,
  parameter int REFRESH_DIV = 100000,
  parameter int LZ_BLANK    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data,
  input  logic              load,
  input  logic              mode,
  input  logic [DIGITS-1:0] dp_mask,
  input  logic              blank,
  output logic              busy,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [DIGITS-1:0] an
);

  localparam int BCD_W = bcd_width(DIGITS);
  localparam int EXT_W = (DATA_W > BCD_W) ? DATA_W : BCD_W;
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CNT_W-1:0]           refresh_q;
  logic [IDX_W-1:0]           idx_q;
  logic [DIGITS-1:0][3:0]     digits_q;
  logic [DIGITS-1:0]          blank_q;
  logic                       ovf_q;

  logic                       conv_busy, conv_done, conv_ovf;
  logic [BCD_W-1:0]           conv_bcd;
  logic [DIGITS-1:0]          lz;
  logic                       higher_nz;
  logic [EXT_W-1:0]           data_ext;
  logic                       accept, hex_load, dec_load;

  logic [6:0]                 seg_next;
  logic                       dp_next;
  logic [DIGITS-1:0]          an_next;

  // A load landing on the DONE cycle is accepted: busy falls on that same edge.
  assign accept   = load & (~conv_busy | conv_done);
  assign hex_load = accept & ~mode;
  assign dec_load = accept & mode;
  assign data_ext = EXT_W'(data);
  assign busy     = conv_busy;

  bin2bcd_seq #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk      (clk),
    .reset    (reset),
    .start    (dec_load),
    .data     (data),
    .busy     (conv_busy),
    .done     (conv_done),
    .bcd      (conv_bcd),
    .overflow (conv_ovf)
  );

  // Leading-zero flags: digit i blanks when it and every digit above it are zero.
  always_comb begin
    lz        = '0;
    higher_nz = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (conv_bcd[4*i +: 4] != 4'd0) higher_nz = 1'b1;
      lz[i] = (LZ_BLANK != 0) && !higher_nz;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digits_q <= '0;
      blank_q  <= '0;
      ovf_q    <= 1'b0;
    end else if (hex_load) begin
      for (int i = 0; i < DIGITS; i++) digits_q[i] <= data_ext[4*i +: 4];
      blank_q <= '0;
      ovf_q   <= 1'b0;
    end else if (conv_done) begin
      digits_q <= conv_bcd;
      blank_q  <= lz;
      ovf_q    <= conv_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_q <= '0;
      idx_q     <= '0;
    end else if (refresh_q == CNT_W'(REFRESH_DIV - 1)) begin
      refresh_q <= '0;
      idx_q     <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end else begin
      refresh_q <= refresh_q + 1'b1;
    end
  end

  always_comb begin
    an_next  = ~(DIGITS'(1) << idx_q);
    dp_next  = ~dp_mask[idx_q];
    seg_next = seg_encode(digits_q[idx_q]);
    if (ovf_q)               seg_next = SEG_DASH;
    else if (blank_q[idx_q]) seg_next = SEG_BLANK;
    if (blank) begin
      an_next  = '1;
      dp_next  = 1'b1;
      seg_next = SEG_BLANK;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= '1;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Scoreboard bench for seg_display_ctrl with REFRESH_DIV=4, other parameters at default.
module tb_seg_display_ctrl;

  localparam int DIGITS     = 4;
  localparam int DATA_W     = 16;
  localparam int RD         = 4;
  localparam int SCAN_BOUND = 2 * DIGITS * RD + 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DATA_W-1:0] data = '0;
  logic              load = 1'b0;
  logic              mode = 1'b0;
  logic [DIGITS-1:0] dp_mask = '0;
  logic              blank = 1'b0;
  logic              busy;
  logic [6:0]        seg;
  logic              dp;
  logic [DIGITS-1:0] an;

  typedef struct {
    string      name;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  seg_display_ctrl #(
    .DIGITS      (DIGITS),
    .DATA_W      (DATA_W),
    .REFRESH_DIV (RD),
    .LZ_BLANK    (1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .data    (data),
    .load    (load),
    .mode    (mode),
    .dp_mask (dp_mask),
    .blank   (blank),
    .busy    (busy),
    .seg     (seg),
    .dp      (dp),
    .an      (an)
  );

  always #5 clk = ~clk;

  task automatic push_frame(input string nm, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3);
    logic [6:0] s [4];
    exp_t e;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int i = 0; i < DIGITS; i++) begin
      e.name = $sformatf("%s_d%0d", nm, i);
      e.an   = ~(4'b0001 << i);
      e.seg  = s[i];
      e.dp   = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  // Pop each expected digit and compare once the scan selects it.
  task automatic drain();
    exp_t e;
    bit   found;
    while (exp_q.size() > 0) begin
      e     = exp_q.pop_front();
      found = 1'b0;
      for (int c = 0; c < SCAN_BOUND && !found; c++) begin
        @(negedge clk);
        if (an === e.an) found = 1'b1;
      end
      tests_run++;
      if (!found) begin
        tests_failed++;
        $display("FAIL %s: an never became %b (last an=%b)", e.name, e.an, an);
      end else if ({seg, dp} !== {e.seg, e.dp}) begin
        tests_failed++;
        $display("FAIL %s: seg=%b dp=%b, expected seg=%b dp=%b", e.name, seg, dp, e.seg, e.dp);
      end
    end
  endtask

  task automatic do_load(input logic [DATA_W-1:0] v, input logic m);
    @(negedge clk);
    data = v;
    mode = m;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_idle(output int busy_cycles, output bit ok);
    busy_cycles = 0;
    ok          = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      if (busy === 1'b0) ok = 1'b1;
      else begin
        busy_cycles++;
        @(negedge clk);
      end
    end
  endtask

  task automatic check_busy(input string nm, input int got, input bit ok, input int want);
    tests_run++;
    if (!ok || got != want) begin
      tests_failed++;
      $display("FAIL %s: busy high %0d cycles (settled=%0d), expected %0d", nm, got, ok, want);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests_run++;
      if ({an, seg, dp, busy} !== {4'b1111, 7'h7F, 1'b1, 1'b0}) begin
        tests_failed++;
        $display("FAIL reset_hold: an=%b seg=%b dp=%b busy=%b, expected 1111 1111111 1 0",
                 an, seg, dp, busy);
      end
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if ({an, seg, dp} !== {4'b1111, 7'h7F, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_release: an=%b seg=%b dp=%b, expected reset values", an, seg, dp);
    end
    for (int ph = 0; ph < 5 * RD; ph++) begin
      @(negedge clk);
      tests_run++;
      if ({an, seg} !== {~(4'b0001 << ((ph / RD) % DIGITS)), 7'b1000000}) begin
        tests_failed++;
        $display("FAIL scan_ph%0d: an=%b seg=%b, expected an=%b seg=1000000",
                 ph, an, seg, ~(4'b0001 << ((ph / RD) % DIGITS)));
      end
    end
  endtask

  task automatic test_hex();
    do_load(16'hBEEF, 1'b0);
    repeat (2) begin
      tests_run++;
      if (busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL hex_busy: busy=%b, expected 0", busy);
      end
      @(negedge clk);
    end
    push_frame("hex_beef", 7'b0001110, 7'b0000110, 7'b0000110, 7'b0000011);
    drain();
  endtask

  task automatic test_decimal();
    int n;
    bit ok;
    do_load(16'd1234, 1'b1);
    wait_idle(n, ok);
    check_busy("dec_1234_busy", n, ok, DATA_W + 1);
    push_frame("dec_1234", 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001);
    drain();

    do_load(16'd7, 1'b1);
    wait_idle(n, ok);
    check_busy("dec_7_busy", n, ok, DATA_W + 1);
    push_frame("dec_7_lz", 7'b1111000, 7'h7F, 7'h7F, 7'h7F);
    drain();

    do_load(16'd65535, 1'b1);
    wait_idle(n, ok);
    check_busy("dec_ovf_busy", n, ok, DATA_W + 1);
    push_frame("dec_ovf", 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111);
    drain();

    do_load(16'd9999, 1'b1);
    wait_idle(n, ok);
    check_busy("dec_9999_busy", n, ok, DATA_W + 1);
    push_frame("dec_9999", 7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000);
    drain();
  endtask

  task automatic test_back_to_back();
    int n;
    bit ok;
    do_load(16'd1234, 1'b1);
    @(negedge clk);
    do_load(16'hFFFF, 1'b0);
    wait_idle(n, ok);
    check_busy("ignored_load_busy", n, ok, DATA_W + 1 - 3);
    push_frame("ignored_load", 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001);
    drain();

    // Second decimal load sampled on the edge where busy falls.
    do_load(16'd1234, 1'b1);
    repeat (DATA_W) @(negedge clk);
    data = 16'd56;
    mode = 1'b1;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_idle(n, ok);
    check_busy("accept_on_fall_busy", n, ok, DATA_W + 1);
    push_frame("accept_on_fall", 7'b0000010, 7'b0010010, 7'h7F, 7'h7F);
    drain();
  endtask

  task automatic test_reset_mid();
    do_load(16'd9876, 1'b1);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({busy, an, seg, dp} !== {1'b0, 4'b1111, 7'h7F, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_mid: busy=%b an=%b seg=%b dp=%b, expected 0 1111 1111111 1",
               busy, an, seg, dp);
    end
    reset = 1'b0;
    repeat (DATA_W + 4) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_idle: busy=%b, expected 0", busy);
    end
    push_frame("reset_mid", 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);
    drain();
  endtask

  task automatic test_dp_blank();
    bit         synced;
    logic       bprev;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    int         dig;
    dp_mask = 4'b0100;
    synced  = 1'b0;
    for (int c = 0; c < SCAN_BOUND && !synced; c++) begin
      @(negedge clk);
      if (an === 4'b0111) synced = 1'b1;
    end
    if (synced) begin
      synced = 1'b0;
      for (int c = 0; c < RD + 2 && !synced; c++) begin
        @(negedge clk);
        if (an === 4'b1110) synced = 1'b1;
      end
    end
    tests_run++;
    if (!synced) begin
      tests_failed++;
      $display("FAIL dp_sync: an=%b, never wrapped 0111->1110", an);
    end else begin
      bprev = 1'b0;
      for (int ph = 0; ph < 2 * DIGITS * RD; ph++) begin
        dig     = (ph / RD) % DIGITS;
        exp_an  = bprev ? 4'b1111 : ~(4'b0001 << dig);
        exp_seg = bprev ? 7'h7F : 7'b1000000;
        exp_dp  = bprev ? 1'b1 : (dig == 2 ? 1'b0 : 1'b1);
        tests_run++;
        if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
          tests_failed++;
          $display("FAIL dp_blank_ph%0d: an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                   ph, an, seg, dp, exp_an, exp_seg, exp_dp);
        end
        blank = (ph >= 9 && ph < 14);
        bprev = blank;
        @(negedge clk);
      end
    end
    blank   = 1'b0;
    dp_mask = '0;
  endtask

  initial begin
    test_reset();
    test_hex();
    test_decimal();
    test_back_to_back();
    test_reset_mid();
    test_dp_blank();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
